// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M multiply/divide unit; optional MULDIV_EARLY_OUT_EN divide early-out
module muldiv_unit #(
    parameter int D_WIDTH  = 32,
    parameter int DIV_BITS = 1,
    parameter int MUL_LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_e,
    input  logic               flush_e,
    input  logic               is_div_e,
    input  logic [1:0]         mul_ctrl_e,
    input  logic [1:0]         div_ctrl_e,
    input  logic [D_WIDTH-1:0] op_a_e,
    input  logic [D_WIDTH-1:0] op_b_e,
    output logic [D_WIDTH-1:0] result_e,
    output logic               done_e,
    output logic               busy_e,
    output logic               stall_e
);
    localparam int W       = D_WIDTH;
    localparam int DIV_CYC = W / DIV_BITS;
    localparam int CNT_W   = $clog2(DIV_CYC + MUL_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state, state_nx;

    // a_q/b_q hold multiply operands, or the dividend shift register and divisor magnitude
    logic [W-1:0]     a_q, a_nx, b_q, b_nx, rem_q, rem_nx, result_nx;
    logic [1:0]       ctrl_q, ctrl_nx;
    logic             q_neg_q, q_neg_nx, r_neg_q, r_neg_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;

    logic             accept, a_sgn, b_sgn, sgn, na, nb, div_zero, ovf, early;
    logic [1:0]       mc;
    logic [W-1:0]     mul_x, mul_y, mul_res, mag_a, mag_b, spec_res, div_res;
    logic [W-1:0]     step_q, step_r, quot, remv;
    logic [W:0]       trial;
    logic [2*W-1:0]   mx, my, prod;

    assign done_e  = (state == S_DONE);
    assign busy_e  = (state != S_IDLE);
    assign stall_e = (start_e & (state == S_IDLE) & ~flush_e) | (busy_e & ~done_e);

    always_comb begin
        accept = start_e & (state == S_IDLE) & ~flush_e;

        // MUL_LAT=1 multiplies straight from the input ports in the accept cycle
        mc    = (state == S_IDLE) ? mul_ctrl_e : ctrl_q;
        mul_x = (state == S_IDLE) ? op_a_e : a_q;
        mul_y = (state == S_IDLE) ? op_b_e : b_q;
        a_sgn = (mc == 2'b01) || (mc == 2'b10);
        b_sgn = (mc == 2'b01);
        mx    = {{W{a_sgn & mul_x[W-1]}}, mul_x};
        my    = {{W{b_sgn & mul_y[W-1]}}, mul_y};
        prod  = mx * my;
        mul_res = (mc == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];

        sgn      = ~div_ctrl_e[0];
        na       = sgn & op_a_e[W-1];
        nb       = sgn & op_b_e[W-1];
        mag_a    = na ? -op_a_e : op_a_e;
        mag_b    = nb ? -op_b_e : op_b_e;
        div_zero = (op_b_e == '0);
        ovf      = sgn && (op_a_e == {1'b1, {(W-1){1'b0}}}) && (op_b_e == {W{1'b1}});
`ifdef MULDIV_EARLY_OUT_EN
        early    = (mag_b > mag_a);
`else
        early    = 1'b0;
`endif
        if (div_zero)  spec_res = div_ctrl_e[1] ? op_a_e : {W{1'b1}};
        else if (ovf)  spec_res = div_ctrl_e[1] ? '0 : {1'b1, {(W-1){1'b0}}};
        else           spec_res = div_ctrl_e[1] ? op_a_e : '0;

        step_q = a_q;
        step_r = rem_q;
        trial  = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            trial  = {step_r, step_q[W-1]};
            step_q = {step_q[W-2:0], 1'b0};
            if (trial >= {1'b0, b_q}) begin
                trial     = trial - {1'b0, b_q};
                step_q[0] = 1'b1;
            end
            step_r = trial[W-1:0];
        end
        quot    = q_neg_q ? -step_q : step_q;
        remv    = r_neg_q ? -step_r : step_r;
        div_res = ctrl_q[1] ? remv : quot;
    end

    always_comb begin
        state_nx  = state;
        a_nx      = a_q;
        b_nx      = b_q;
        rem_nx    = rem_q;
        ctrl_nx   = ctrl_q;
        q_neg_nx  = q_neg_q;
        r_neg_nx  = r_neg_q;
        cnt_nx    = cnt_q;
        result_nx = result_e;
        case (state)
            S_IDLE: begin
                if (accept && !is_div_e) begin
                    a_nx    = op_a_e;
                    b_nx    = op_b_e;
                    ctrl_nx = mul_ctrl_e;
                    if (MUL_LAT == 1) begin
                        state_nx  = S_DONE;
                        result_nx = mul_res;
                    end else begin
                        state_nx = S_MUL;
                        cnt_nx   = CNT_W'(MUL_LAT - 1);
                    end
                end else if (accept && (div_zero || ovf || early)) begin
                    state_nx  = S_DONE;
                    result_nx = spec_res;
                end else if (accept) begin
                    state_nx = S_DIV;
                    a_nx     = mag_a;
                    b_nx     = mag_b;
                    rem_nx   = '0;
                    ctrl_nx  = div_ctrl_e;
                    q_neg_nx = na ^ nb;
                    r_neg_nx = na;
                    cnt_nx   = CNT_W'(DIV_CYC);
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_nx  = S_DONE;
                    result_nx = mul_res;
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            S_DIV: begin
                a_nx   = step_q;
                rem_nx = step_r;
                cnt_nx = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_nx  = S_DONE;
                    result_nx = div_res;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (flush_e) begin
            state_nx  = S_IDLE;
            result_nx = result_e;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            ctrl_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            cnt_q    <= '0;
            result_e <= '0;
        end else begin
            state    <= state_nx;
            a_q      <= a_nx;
            b_q      <= b_nx;
            rem_q    <= rem_nx;
            ctrl_q   <= ctrl_nx;
            q_neg_q  <= q_neg_nx;
            r_neg_q  <= r_neg_nx;
            cnt_q    <= cnt_nx;
            result_e <= result_nx;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    localparam int W        = 32;
    localparam int DIV_BITS = 1;
    localparam int MUL_LAT  = 2;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst, start_e, flush_e, is_div_e;
    logic [1:0]   mul_ctrl_e, div_ctrl_e;
    logic [W-1:0] op_a_e, op_b_e, result_e;
    logic         done_e, busy_e, stall_e;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] last_res = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.D_WIDTH(W), .DIV_BITS(DIV_BITS), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .start_e(start_e), .flush_e(flush_e), .is_div_e(is_div_e),
        .mul_ctrl_e(mul_ctrl_e), .div_ctrl_e(div_ctrl_e), .op_a_e(op_a_e), .op_b_e(op_b_e),
        .result_e(result_e), .done_e(done_e), .busy_e(busy_e), .stall_e(stall_e)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_mul(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        longint x, y, p;
        x = (c == 2'b01 || c == 2'b10) ? longint'($signed(a)) : longint'(a);
        y = (c == 2'b01) ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return (c == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [W-1:0] ref_div(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == 0) return c[1] ? a : 32'hFFFF_FFFF;
        sa = c[0] ? longint'(a) : longint'($signed(a));
        sb = c[0] ? longint'(b) : longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        return c[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int div_lat(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ma, mb;
        if (b == 0) return 1;
        if (!c[0] && a == MIN && b == 32'hFFFF_FFFF) return 1;
        ma = c[0] ? longint'(a) : longint'($signed(a));
        mb = c[0] ? longint'(b) : longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef MULDIV_EARLY_OUT_EN
        if (mb > ma) return 1;
`endif
        return W / DIV_BITS + 1;
    endfunction

    function automatic logic [W-1:0] pick_op();
        case ($urandom % 4)
            0: return $urandom_range(0, 40);
            1: case ($urandom % 4)
                   0: return MIN;
                   1: return 32'hFFFF_FFFF;
                   2: return 32'h0;
                   default: return 32'h7FFF_FFFF;
               endcase
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1 with the unit idle; returns at posedge+1 with it idle again
    task automatic run_op(input string tag, input logic is_div, input logic [1:0] c,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        logic [W-1:0] exp_r;
        int exp_lat, lat;
        bit seen, stall_ok;
        exp_r   = is_div ? ref_div(c, a, b) : ref_mul(c, a, b);
        exp_lat = is_div ? div_lat(c, a, b) : MUL_LAT;
        is_div_e = is_div; mul_ctrl_e = c; div_ctrl_e = c;
        op_a_e = a; op_b_e = b; start_e = 1'b1;
        #1;
        check({tag, " stall_accept"}, W'(stall_e), W'(1));
        @(posedge clk); #1;
        start_e = hold;
        op_a_e = $urandom; op_b_e = $urandom;
        mul_ctrl_e = 2'($urandom); div_ctrl_e = 2'($urandom);
        lat = 1; seen = 0; stall_ok = 1;
        while (lat <= 100) begin
            if (done_e) begin seen = 1; break; end
            if (stall_e !== 1'b1 || busy_e !== 1'b1) stall_ok = 0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " done_seen"}, W'(seen), W'(1));
        check({tag, " latency"}, W'(lat), W'(exp_lat));
        check({tag, " result"}, result_e, exp_r);
        check({tag, " stall_busy_inflight"}, W'(stall_ok), W'(1));
        check({tag, " stall_done"}, W'(stall_e), W'(0));
        start_e = 1'b0;
        @(posedge clk); #1;
        check({tag, " done_pulse"}, W'({done_e, busy_e}), W'(0));
        check({tag, " result_held"}, result_e, exp_r);
        last_res = exp_r;
    endtask

    initial begin
        rst = 1'b1; start_e = 0; flush_e = 0; is_div_e = 0;
        mul_ctrl_e = 0; div_ctrl_e = 0; op_a_e = 0; op_b_e = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result_e, '0);
        check("reset flags", W'({done_e, busy_e, stall_e}), W'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul_7x-3", 0, 2'b00, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("mulhu_max", 0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu_-1x2", 0, 2'b10, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("mulh_min", 0, 2'b01, MIN, MIN, 0);
        run_op("div_-20/3", 1, 2'b00, 32'hFFFF_FFEC, 32'd3, 0);
        run_op("rem_-20/3", 1, 2'b10, 32'hFFFF_FFEC, 32'd3, 0);
        run_op("divu_5/0", 1, 2'b01, 32'd5, 32'd0, 0);
        run_op("rem_5/0", 1, 2'b10, 32'd5, 32'd0, 0);
        run_op("div_ovf", 1, 2'b00, MIN, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 1, 2'b10, MIN, 32'hFFFF_FFFF, 0);
        run_op("divu_3/10", 1, 2'b01, 32'd3, 32'd10, 0);
        run_op("rem_-3/10", 1, 2'b10, 32'hFFFF_FFFD, 32'd10, 0);
        run_op("div_held_start", 1, 2'b00, 32'd1000, 32'hFFFF_FFF9, 1);

        begin : flush_mid_div
            bit no_done;
            is_div_e = 1; div_ctrl_e = 2'b00; op_a_e = 32'hFFFF_FFEC; op_b_e = 32'd3; start_e = 1;
            @(posedge clk); #1;
            start_e = 0;
            no_done = 1;
            repeat (9) begin
                if (done_e) no_done = 0;
                @(posedge clk); #1;
            end
            flush_e = 1;
            @(posedge clk); #1;
            flush_e = 0;
            check("flush no_done", W'(no_done), W'(1));
            check("flush idle", W'({done_e, busy_e}), W'(0));
            check("flush result_kept", result_e, last_res);
            run_op("mul_after_flush", 0, 2'b00, 32'd12345, 32'd678, 0);
        end

        is_div_e = 0; start_e = 1; flush_e = 1; op_a_e = 32'd3; op_b_e = 32'd4;
        #1;
        check("flush_start stall", W'(stall_e), W'(0));
        @(posedge clk); #1;
        start_e = 0; flush_e = 0;
        check("flush_start not_accepted", W'(busy_e), W'(0));

        is_div_e = 1; div_ctrl_e = 2'b01; op_a_e = 32'd999; op_b_e = 32'd7; start_e = 1;
        @(posedge clk); #1;
        start_e = 0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rst_mid result", result_e, '0);
        check("rst_mid flags", W'({done_e, busy_e}), W'(0));
        last_res = '0;

        for (int i = 0; i < 30; i++) begin
            logic d;
            d = 1'($urandom);
            run_op(d ? "rand_div" : "rand_mul", d, 2'($urandom), pick_op(), pick_op(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
